output_writeback: RTL and testbench



---
 rtl/output_writeback.sv | 204 ++++++++++++++++++++
 tb/tb_output_writeback.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_writeback.sv
// Output writeback: captures accelerator result beats into a small FIFO and streams them to external memory.
// Build option: define WB_OVERFLOW_FLAG_EN to report beats dropped on a full FIFO through overflow_err.
module output_writeback #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int BASE_ADDR          = 0,
  parameter int FIFO_DEPTH         = 4,
  localparam int AW = $clog2(EXT_MEM_HEIGHT),
  localparam int XW = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  input  logic [XW-1:0]                 in_x,
  input  logic [YW-1:0]                 in_y,
  input  logic [CW-1:0]                 in_ch,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [ACCUMULATION_WIDTH-1:0] mem_wdata,
  input  logic                          mem_ack,
  output logic                          busy,
  output logic                          done,
  output logic [AW:0]                   wr_count,
  output logic                          overflow_err
);

  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int TW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = ((AW > XW + YW + CW) ? AW : (XW + YW + CW)) + 2;
  localparam int EW    = AW + ACCUMULATION_WIDTH;

  localparam logic [TW-1:0] LAST_BEAT = TW'(TOTAL - 1);
  localparam logic [PW:0]   DEPTH_P   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] MEM_H     = LW'(EXT_MEM_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                          in_range;
  logic                          beat;
  logic                          last_beat;
  logic                          run_entry;
  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          fifo_empty_d;
  logic [LW-1:0]                 lin_addr;
  logic [AW-1:0]                 cap_addr;
  logic [EW-1:0]                 cap_entry;
  logic [EW-1:0]                 head_d;
  logic [EW-1:0]                 fifo_q [FIFO_DEPTH];
  logic [PW:0]                   wr_ptr_q, wr_ptr_d;
  logic [PW:0]                   rd_ptr_q, rd_ptr_d;
  logic [PW:0]                   level;
  logic                          mem_we_q;
  logic [AW-1:0]                 mem_addr_q;
  logic [ACCUMULATION_WIDTH-1:0] mem_wdata_q;
  logic [AW:0]                   wr_count_q;
  logic [TW-1:0]                 beat_cnt_q;

  // Capture qualification and address generation
  always_comb begin
    in_range = ({1'b0, in_x}  < (XW + 1)'(FEATURE_MAP_WIDTH)) &&
               ({1'b0, in_y}  < (YW + 1)'(FEATURE_MAP_HEIGHT)) &&
               ({1'b0, in_ch} < (CW + 1)'(OUTPUT_NB_CHANNELS));
    lin_addr  = LW'(BASE_ADDR) +
                (LW'(in_ch) * LW'(FEATURE_MAP_HEIGHT) + LW'(in_y)) * LW'(FEATURE_MAP_WIDTH) +
                LW'(in_x);
    cap_addr  = AW'(lin_addr % MEM_H);
    cap_entry = {cap_addr, in_data};
  end

  always_comb begin
    beat      = (state_q == S_RUN) && in_valid && in_range;
    last_beat = beat && (beat_cnt_q == LAST_BEAT);
    run_entry = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    level     = wr_ptr_q - rd_ptr_q;
    full      = (level == DEPTH_P);
    pop       = mem_we_q && mem_ack;
    push      = beat && (!full || pop);
  end

  // The output register tracks the FIFO head as it will be after this edge:
  // a push into a FIFO that empties this edge becomes the head directly.
  always_comb begin
    rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);
    wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    if (run_entry) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
    fifo_empty_d = (rd_ptr_d == wr_ptr_d);
    if (push && (level == (PW + 1)'(pop))) begin
      head_d = cap_entry;
    end else begin
      head_d = fifo_q[rd_ptr_d[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= cap_entry;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)        state_d = S_RUN;
      S_RUN:   if (last_beat)    state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty_d) state_d = S_DONE;
      S_DONE:  if (start)        state_d = S_RUN;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_we_q <= !fifo_empty_d;
      if (!fifo_empty_d) begin
        mem_addr_q  <= head_d[EW-1 -: AW];
        mem_wdata_q <= head_d[ACCUMULATION_WIDTH-1:0];
      end
      if (run_entry) begin
        wr_count_q <= '0;
        beat_cnt_q <= '0;
      end else begin
        if (pop) begin
          wr_count_q <= wr_count_q + (AW + 1)'(1);
        end
        if (beat) begin
          beat_cnt_q <= beat_cnt_q + TW'(1);
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_count  = wr_count_q;

`ifdef WB_OVERFLOW_FLAG_EN
  logic drop;
  logic ovf_q;

  assign drop = beat && full && !pop;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      ovf_q <= 1'b0;
    end else if (run_entry) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: scoreboard of expected memory writes
// plus per-scenario checks of control outputs.
module tb_output_writeback;

  localparam int ACC   = 32;
  localparam int FMW   = 64;
  localparam int FMH   = 64;
  localparam int OC    = 3;
  localparam int EMH   = 1 << 20;
  localparam int BASE  = 0;
  localparam int DEPTH = 4;
  localparam int AW    = 20;
  localparam int XW    = 6;
  localparam int YW    = 6;
  localparam int CW    = 2;
  localparam int TOTAL = FMW * FMH * OC;

`ifdef WB_OVERFLOW_FLAG_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_in;
  logic           start;
  logic [ACC-1:0] in_data;
  logic           in_valid;
  logic [XW-1:0]  in_x;
  logic [YW-1:0]  in_y;
  logic [CW-1:0]  in_ch;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [ACC-1:0] mem_wdata;
  logic           mem_ack;
  logic           busy;
  logic           done;
  logic [AW:0]    wr_count;
  logic           overflow_err;

  int checks = 0;
  int errors = 0;

  logic [AW+ACC-1:0] sb_q [$];
  logic [AW+ACC-1:0] sb_exp;

  always #5 clk = ~clk;

  output_writeback #(
    .ACCUMULATION_WIDTH (ACC),
    .FEATURE_MAP_WIDTH  (FMW),
    .FEATURE_MAP_HEIGHT (FMH),
    .OUTPUT_NB_CHANNELS (OC),
    .EXT_MEM_HEIGHT     (EMH),
    .BASE_ADDR          (BASE),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_ch        (in_ch),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .done         (done),
    .wr_count     (wr_count),
    .overflow_err (overflow_err)
  );

  // Every accepted write (mem_we && mem_ack, no reset) must match the oldest expected entry.
  always @(negedge clk) begin
    if (mem_we && mem_ack && !rst_in) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got addr=%0d data=%h, want no write", mem_addr, mem_wdata);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({mem_addr, mem_wdata} !== sb_exp) begin
          errors++;
          $display("FAIL sb_write got addr=%0d data=%h, want addr=%0d data=%h",
                   mem_addr, mem_wdata, sb_exp[AW+ACC-1 -: AW], sb_exp[ACC-1:0]);
        end
      end
    end
  end

  function automatic logic [AW-1:0] addr_of(input int x, input int y, input int ch);
    int a;
    a = (BASE + (ch * FMH + y) * FMW + x) % EMH;
    return AW'(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raster beats lo..hi back to back; beats in drop_lo..drop_hi are expected to be lost.
  task automatic drive_range(input int lo, input int hi, input int drop_lo, input int drop_hi);
    int x, y, ch;
    for (int i = lo; i <= hi; i++) begin
      x  = i % FMW;
      y  = (i / FMW) % FMH;
      ch = i / (FMW * FMH);
      in_x     = XW'(x);
      in_y     = YW'(y);
      in_ch    = CW'(ch);
      in_data  = $urandom;
      in_valid = 1'b1;
      if (i < drop_lo || i > drop_hi) sb_q.push_back({addr_of(x, y, ch), in_data});
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    checks++;
    if ({mem_we, busy, done, overflow_err, wr_count, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b busy=%b done=%b ovf=%b cnt=%0d addr=%0d data=%h, want all 0",
               mem_we, busy, done, overflow_err, wr_count, mem_addr, mem_wdata);
    end
    rst_in = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_single_beat();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_run got busy=%b done=%b, want 1 0", busy, done);
    end
    mem_ack  = 1'b0;
    in_x     = 6'd3;
    in_y     = 6'd2;
    in_ch    = 2'd1;
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    sb_q.push_back({addr_of(3, 2, 1), 32'hDEADBEEF});
    step();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'd4227 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_latency got we=%b addr=%0d data=%h, want 1 4227 deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 20'd4227 || mem_wdata !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL single_hold got we=%b addr=%0d data=%h, want 1 4227 deadbeef",
                 mem_we, mem_addr, mem_wdata);
      end
    end
    mem_ack = 1'b1;
    step();
    checks++;
    if (mem_we !== 1'b0 || wr_count !== 21'd1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_ack got we=%b cnt=%0d pending=%0d, want 0 1 0", mem_we, wr_count, sb_q.size());
    end
  endtask

  task automatic test_out_of_range();
    in_x     = 6'd0;
    in_y     = 6'd0;
    in_ch    = 2'd3;
    in_data  = 32'h0BAD0BAD;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (mem_we !== 1'b0 || wr_count !== 21'd1 || overflow_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL out_of_range got we=%b cnt=%0d ovf=%b busy=%b, want 0 1 0 1",
               mem_we, wr_count, overflow_err, busy);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (wr_count !== 21'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run got cnt=%0d busy=%b done=%b, want 1 1 0", wr_count, busy, done);
    end
    in_x     = 6'd4;
    in_y     = 6'd2;
    in_ch    = 2'd1;
    in_data  = 32'h12345678;
    in_valid = 1'b1;
    sb_q.push_back({addr_of(4, 2, 1), 32'h12345678});
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (wr_count !== 21'd2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL run_continues got cnt=%0d pending=%0d, want 2 0", wr_count, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    mem_ack  = 1'b0;
    in_x     = 6'd5;
    in_y     = 6'd2;
    in_ch    = 2'd1;
    in_data  = 32'hCAFEF00D;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending got we=%b, want 1", mem_we);
    end
    rst_in  = 1'b1;
    start   = 1'b1;
    mem_ack = 1'b1;
    step();
    rst_in = 1'b0;
    start  = 1'b0;
    checks++;
    if ({mem_we, busy, done, overflow_err, wr_count, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_write got we=%b busy=%b done=%b ovf=%b cnt=%0d addr=%0d data=%h, want all 0",
               mem_we, busy, done, overflow_err, wr_count, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority got busy=%b we=%b, want 0 0", busy, mem_we);
    end
    sb_q.delete();
  endtask

  task automatic test_full_tensor();
    mem_ack = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    drive_range(0, TOTAL - 1, -1, -1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL drain_state got busy=%b done=%b we=%b, want 1 0 1", busy, done, mem_we);
    end
    wait_done(50);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 21'(TOTAL) || sb_q.size() != 0 ||
        overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done=%b busy=%b cnt=%0d pending=%0d ovf=%b, want 1 0 %0d 0 0",
               done, busy, wr_count, sb_q.size(), overflow_err, TOTAL);
    end
    in_x     = 6'd1;
    in_y     = 6'd1;
    in_ch    = 2'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (mem_we !== 1'b0 || wr_count !== 21'(TOTAL) || done !== 1'b1) begin
      errors++;
      $display("FAIL valid_in_done got we=%b cnt=%0d done=%b, want 0 %0d 1", mem_we, wr_count, done, TOTAL);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (wr_count !== 21'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_done got cnt=%0d busy=%b done=%b, want 0 1 0", wr_count, busy, done);
    end
    mem_ack = 1'b0;
    drive_range(0, 5, 4, 5);
    repeat (4) step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 20'd0 || wr_count !== 21'd0 || overflow_err !== EXP_OVF) begin
      errors++;
      $display("FAIL overflow_stall got we=%b addr=%0d cnt=%0d ovf=%b, want 1 0 0 %b",
               mem_we, mem_addr, wr_count, overflow_err, EXP_OVF);
    end
    mem_ack = 1'b1;
    drive_range(6, TOTAL - 1, -1, -1);
    wait_done(50);
    checks++;
    if (done !== 1'b1 || wr_count !== 21'(TOTAL - 2) || overflow_err !== EXP_OVF || sb_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_done got done=%b cnt=%0d ovf=%b pending=%0d, want 1 %0d %b 0",
               done, wr_count, overflow_err, sb_q.size(), TOTAL - 2, EXP_OVF);
    end
  endtask

  task automatic test_restart_clears();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (overflow_err !== 1'b0 || wr_count !== 21'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears got ovf=%b cnt=%0d busy=%b done=%b, want 0 0 1 0",
               overflow_err, wr_count, busy, done);
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in   = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_x     = '0;
    in_y     = '0;
    in_ch    = '0;
    mem_ack  = 1'b1;
    test_reset();
    test_single_beat();
    test_out_of_range();
    test_start_ignored();
    test_reset_mid_write();
    test_full_tensor();
    test_overflow();
    test_restart_clears();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
